// File: rtl/io_port_bank_if.sv
// io_port_bank_if: bus, strobe and handshake signals of the I/O port bank.
//   slave  : the port bank itself (consumes control + external inputs, drives results)
//   master : the control unit / external world driving the bank
//   bus_in/bus_out  datapath bus write/read data
//   ch_sel/out_in/in_out  channel select and transfer commands from the control unit
//   in_port/in_strobe/in_avail/in_overrun  input-channel side, WIDTH bits per channel
//   out_port/out_valid/out_ack  output-channel side with valid/ack handshake
interface io_port_bank_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]          bus_in;
    logic [SEL_W-1:0]          ch_sel;
    logic                      out_in;
    logic                      in_out;
    logic [WIDTH-1:0]          bus_out;
    logic [CHANNELS*WIDTH-1:0] in_port;
    logic [CHANNELS-1:0]       in_strobe;
    logic [CHANNELS-1:0]       in_avail;
    logic [CHANNELS-1:0]       in_overrun;
    logic [CHANNELS*WIDTH-1:0] out_port;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ack;

    modport slave (
        input  bus_in, ch_sel, out_in, in_out, in_port, in_strobe, out_ack,
        output bus_out, in_avail, in_overrun, out_port, out_valid
    );

    modport master (
        output bus_in, ch_sel, out_in, in_out, in_port, in_strobe, out_ack,
        input  bus_out, in_avail, in_overrun, out_port, out_valid
    );
endinterface

// File: rtl/io_port_bank.sv
// io_port_bank: multi-channel I/O port unit for the processor datapath.
//   Each input channel has a DEPTH-entry FIFO pushed on the rising edge of its
//   strobe and popped by in_out (zero-latency head read onto bus_out). Each output
//   channel has a data register loaded by out_in, with a valid/ack handshake.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   pb    io_port_bank_if.slave (bus, channel select, port data, strobes, handshakes)
module io_port_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input logic            clk,
    input logic            rst_n,
    io_port_bank_if.slave  pb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Widened select so the range check never degenerates to a constant compare
    logic [31:0] w_sel;
    logic        w_sel_ok;
    assign w_sel    = 32'(pb.ch_sel);
    assign w_sel_ok = (w_sel < 32'(CHANNELS));

    logic [CHANNELS-1:0]            w_pop;
    logic [CHANNELS-1:0][WIDTH-1:0] w_head;
    logic [WIDTH-1:0]               w_bus_out;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_rd_ptr;
        logic [PTR_W-1:0] r_wr_ptr;
        logic [CNT_W-1:0] r_cnt;
        logic             r_hist;
        logic             r_ovr;
        logic [WIDTH-1:0] r_out_data;
        logic             r_out_vld;
        logic             w_hit;
        logic             w_push;
        logic             w_full;
        logic             w_accept;

        assign w_hit    = w_sel_ok && (w_sel == 32'(g));
        assign w_head[g] = r_mem[r_rd_ptr];
        assign w_pop[g] = pb.in_out && w_hit && (r_cnt != '0);
        assign w_push   = pb.in_strobe[g] && !r_hist;
        assign w_full   = (r_cnt == CNT_W'(DEPTH));
        // A full FIFO still takes the push when the same edge frees a slot
        assign w_accept = w_push && (!w_full || w_pop[g]);

        // Storage needs no reset: the pointers/count define what is valid
        always_ff @(posedge clk) begin
            if (w_accept) r_mem[r_wr_ptr] <= pb.in_port[g*WIDTH +: WIDTH];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_cnt      <= '0;
                r_hist     <= 1'b1;  // strobe held through reset must not push
                r_ovr      <= 1'b0;
                r_out_data <= '0;
                r_out_vld  <= 1'b0;
            end else begin
                r_hist <= pb.in_strobe[g];
                if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop[g]) r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cnt <= r_cnt + CNT_W'(w_accept) - CNT_W'(w_pop[g]);
                // Set needs "no pop", so set and clear never collide
                if (w_push && w_full && !w_pop[g]) r_ovr <= 1'b1;
                else if (w_pop[g])                 r_ovr <= 1'b0;

                if (pb.out_in && w_hit) begin
                    r_out_data <= pb.bus_in;
                    r_out_vld  <= 1'b1;
                end else if (pb.out_ack[g]) begin
                    r_out_vld  <= 1'b0;
                end
            end
        end

        assign pb.in_avail[g]                 = (r_cnt != '0);
        assign pb.in_overrun[g]               = r_ovr;
        assign pb.out_port[g*WIDTH +: WIDTH]  = r_out_data;
        assign pb.out_valid[g]                = r_out_vld;
    end

    // At most one channel pops per cycle, so a priority loop is a plain mux
    always_comb begin
        w_bus_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_pop[i]) w_bus_out = w_head[i];
        end
    end

    assign pb.bus_out = w_bus_out;
endmodule
